// File: rtl/vga_text_pkg.sv
// ---------------------------------------------------------------------------
// vga_text_pkg
//   Shared definitions for the VGA text-console writer:
//     - default screen geometry (COLS_DEFAULT x ROWS_DEFAULT = CELLS)
//     - CLEAR_WORD: the cell value written by both clear sequences
//     - control-code constants BS, LF, FF, CR and the blank glyph SPACE
//     - writer_state_t: writer FSM states
//     - cell_word(): packs {attr, code} into a text-buffer word
// ---------------------------------------------------------------------------
package vga_text_pkg;

    localparam int COLS_DEFAULT = 100;
    localparam int ROWS_DEFAULT = 60;
    localparam int CELLS        = COLS_DEFAULT * ROWS_DEFAULT;

    // Blank cell: space glyph, fg=7, bg=0.
    localparam logic [15:0] CLEAR_WORD = 16'h3820;

    // Control codes acted on by the writer; every other code is a glyph.
    localparam logic [7:0] BS    = 8'h08;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] FF    = 8'h0C;
    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        CLEAR_ALL = 2'd0,
        IDLE      = 2'd1,
        CLEAR_ROW = 2'd2
    } writer_state_t;

    // Text-buffer word layout: {2'b00, fg[2:0], bg[2:0], code[7:0]}.
    function automatic logic [15:0] cell_word(input logic [5:0] attr,
                                              input logic [7:0] code);
        return {2'b00, attr, code};
    endfunction

endpackage

// File: rtl/vga_console_writer.sv
// ---------------------------------------------------------------------------
// vga_console_writer
//   Turns a stream of character bytes into writes to a COLS x ROWS text
//   buffer, handling CR, LF, BS and FF, row wrap and screen clearing.
//
//   Ports
//     clock       rising-edge clock, shared with the text-buffer write port
//     reset       asynchronous active-high reset
//     char_valid  a character byte is offered
//     char_data   character code
//     char_attr   {fg[2:0], bg[2:0]}, sampled with char_data
//     char_ready  writer accepts a character this cycle (state == IDLE)
//     wenable     text-buffer write strobe (registered)
//     waddr       cell address row*COLS+col (registered)
//     wdata       cell word {2'b00, attr, code} (registered)
//     cursor_row  current cursor row
//     cursor_col  current cursor column
//     busy        high while a clear sequence is running
//
//   Behaviour summary
//     After reset the whole screen is cleared.  A glyph is written at the
//     cursor one cycle after acceptance and the cursor advances; running off
//     the last column performs a row advance.  A row advance moves down one
//     row (wrapping to row 0) and blanks that row before accepting more
//     input.  FF homes the cursor and re-clears the whole screen.
// ---------------------------------------------------------------------------
module vga_console_writer
    import vga_text_pkg::*;
#(
    parameter int COLS = COLS_DEFAULT,
    parameter int ROWS = ROWS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [5:0]  char_attr,
    output logic        char_ready,
    output logic        wenable,
    output logic [15:0] waddr,
    output logic [15:0] wdata,
    output logic [6:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy
);

    localparam int SCREEN_CELLS = ROWS * COLS;
    // The clear counter runs one past the last cell so the FSM can spend one
    // extra cycle in the clear state after the final write.
    localparam int CNT_W = $clog2(SCREEN_CELLS + 1);

    localparam logic [CNT_W-1:0] SCREEN_END = CNT_W'(SCREEN_CELLS);
    localparam logic [CNT_W-1:0] ROW_END    = CNT_W'(COLS);
    localparam logic [6:0]       LAST_COL   = 7'(COLS - 1);
    localparam logic [6:0]       LAST_ROW   = 7'(ROWS - 1);

    writer_state_t    state_reg;
    logic [CNT_W-1:0] clr_cnt_reg;
    logic [6:0]       row_reg;
    logic [6:0]       col_reg;

    logic [6:0]       row_adv;   // row after a row advance, with wrap

    // Linear cell address; evaluated inside the clocked block so the
    // multiply feeds the waddr register directly.
    function automatic logic [15:0] cell_addr(input int r, input int c);
        return 16'(r * COLS + c);
    endfunction

    assign row_adv    = (row_reg == LAST_ROW) ? 7'd0 : row_reg + 7'd1;

    assign char_ready = (state_reg == IDLE);
    assign busy       = (state_reg != IDLE);
    assign cursor_row = row_reg;
    assign cursor_col = col_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= CLEAR_ALL;
            clr_cnt_reg <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            wenable     <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
        end else begin
            // No write unless a branch below issues one.
            wenable <= 1'b0;

            case (state_reg)
                CLEAR_ALL: begin
                    if (clr_cnt_reg == SCREEN_END) begin
                        state_reg <= IDLE;
                    end else begin
                        wenable     <= 1'b1;
                        waddr       <= 16'(clr_cnt_reg);
                        wdata       <= CLEAR_WORD;
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end

                CLEAR_ROW: begin
                    // row_reg already holds the new row; the counter walks
                    // its columns in ascending order.
                    if (clr_cnt_reg == ROW_END) begin
                        state_reg <= IDLE;
                    end else begin
                        wenable     <= 1'b1;
                        waddr       <= cell_addr(int'(row_reg), int'(clr_cnt_reg));
                        wdata       <= CLEAR_WORD;
                        clr_cnt_reg <= clr_cnt_reg + 1'b1;
                    end
                end

                IDLE: begin
                    if (char_valid) begin
                        case (char_data)
                            CR: begin
                                col_reg <= '0;
                            end

                            LF: begin
                                col_reg     <= '0;
                                row_reg     <= row_adv;
                                clr_cnt_reg <= '0;
                                state_reg   <= CLEAR_ROW;
                            end

                            FF: begin
                                col_reg     <= '0;
                                row_reg     <= '0;
                                clr_cnt_reg <= '0;
                                state_reg   <= CLEAR_ALL;
                            end

                            BS: begin
                                // Backspace at column 0 is ignored entirely.
                                if (col_reg != 7'd0) begin
                                    col_reg <= col_reg - 7'd1;
                                    wenable <= 1'b1;
                                    waddr   <= cell_addr(int'(row_reg),
                                                         int'(col_reg) - 1);
                                    wdata   <= cell_word(char_attr, SPACE);
                                end
                            end

                            default: begin
                                // Every non-control code, 0x00-0x1F included,
                                // is a glyph.
                                wenable <= 1'b1;
                                waddr   <= cell_addr(int'(row_reg), int'(col_reg));
                                wdata   <= cell_word(char_attr, char_data);
                                if (col_reg == LAST_COL) begin
                                    col_reg     <= '0;
                                    row_reg     <= row_adv;
                                    clr_cnt_reg <= '0;
                                    state_reg   <= CLEAR_ROW;
                                end else begin
                                    col_reg <= col_reg + 7'd1;
                                end
                            end
                        endcase
                    end
                end

                default: begin
                    // Unreachable encoding: recover through a full clear.
                    state_reg   <= CLEAR_ALL;
                    clr_cnt_reg <= '0;
                    row_reg     <= '0;
                    col_reg     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_console_writer.sv
// ---------------------------------------------------------------------------
// tb_vga_console_writer
//   Self-checking bench for vga_console_writer (100 x 60 screen).
//   A cursor/screen reference model predicts, for every accepted character,
//   the exact list of (cycle offset, address, data) writes, the cycle on
//   which char_ready returns, and the resulting cursor.  Offsets count
//   falling edges after the accepting rising edge, starting at 0.
// ---------------------------------------------------------------------------
module tb_vga_console_writer;

    localparam int COLS = 100;
    localparam int ROWS = 60;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data = 8'h00;
    logic [5:0]  char_attr = 6'h00;
    logic        char_ready;
    logic        wenable;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [6:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;

    vga_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clock      (clock),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_attr  (char_attr),
        .char_ready (char_ready),
        .wenable    (wenable),
        .waddr      (waddr),
        .wdata      (wdata),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    bit dead   = 0;

    // ---------------- reference model ----------------
    typedef struct {
        int          off;
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  exp_ready_off;
    int  m_row = 0;
    int  m_col = 0;

    task automatic model_row_advance(input int first_off);
        m_row = (m_row + 1) % ROWS;
        for (int i = 0; i < COLS; i++)
            exp_q.push_back('{first_off + i, 16'(m_row * COLS + i), 16'h3820});
        exp_ready_off = first_off + COLS;
    endtask

    task automatic model_full_clear(input int first_off);
        for (int i = 0; i < ROWS * COLS; i++)
            exp_q.push_back('{first_off + i, 16'(i), 16'h3820});
        exp_ready_off = first_off + ROWS * COLS;
    endtask

    task automatic model_predict(input logic [7:0] code, input logic [5:0] attr);
        exp_q.delete();
        exp_ready_off = 0;
        if (code == 8'h0D) begin
            m_col = 0;
        end else if (code == 8'h0A) begin
            m_col = 0;
            model_row_advance(1);
        end else if (code == 8'h0C) begin
            m_row = 0;
            m_col = 0;
            model_full_clear(1);
        end else if (code == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                exp_q.push_back('{0, 16'(m_row * COLS + m_col), {2'b00, attr, 8'h20}});
            end
        end else begin
            exp_q.push_back('{0, 16'(m_row * COLS + m_col), {2'b00, attr, code}});
            m_col++;
            if (m_col == COLS) begin
                m_col = 0;
                model_row_advance(1);
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Watches the write port starting at the next falling edge and compares
    // it against exp_q until char_ready is seen.
    task automatic collect(input string nm, output int nw,
                           output logic [15:0] fa, output logic [15:0] fd);
        int  idx;
        int  ready_at;
        bit  bad;
        bit  done;
        idx = 0; ready_at = -1; bad = 0; done = 0;
        nw = 0; fa = '0; fd = '0;
        for (int j = 0; j <= exp_ready_off + 64 && !done; j++) begin
            @(negedge clock);
            if (wenable === 1'b1) begin
                if (nw == 0) begin
                    fa = waddr;
                    fd = wdata;
                end
                nw++;
                if (!bad) begin
                    if (idx >= exp_q.size()) begin
                        bad = 1;
                        $display("FAIL %s extra write at cycle %0d: got addr=%0d data=%h, expected none",
                                 nm, j, waddr, wdata);
                    end else if (exp_q[idx].off != j || exp_q[idx].addr !== waddr ||
                                 exp_q[idx].data !== wdata) begin
                        bad = 1;
                        $display("FAIL %s write %0d at cycle %0d: got addr=%0d data=%h, expected cycle %0d addr=%0d data=%h",
                                 nm, idx, j, waddr, wdata, exp_q[idx].off,
                                 exp_q[idx].addr, exp_q[idx].data);
                    end
                end
                idx++;
            end else if (!bad && idx < exp_q.size() && exp_q[idx].off == j) begin
                bad = 1;
                $display("FAIL %s missing write %0d at cycle %0d: got wenable=%b, expected addr=%0d data=%h",
                         nm, idx, j, wenable, exp_q[idx].addr, exp_q[idx].data);
            end
            if (char_ready === 1'b1) begin
                done = 1;
                ready_at = j;
            end
        end

        checks++;
        if (bad || nw != exp_q.size()) begin
            errors++;
            if (!bad)
                $display("FAIL %s write count: got %0d, expected %0d", nm, nw, exp_q.size());
        end
        chk({nm, " ready cycle"}, ready_at, exp_ready_off);
        if (!done) dead = 1;
        chk({nm, " cursor_row"}, int'(cursor_row), m_row);
        chk({nm, " cursor_col"}, int'(cursor_col), m_col);
        chk({nm, " busy when ready"}, int'(busy), 0);
    endtask

    task automatic send(input logic [7:0] code, input logic [5:0] attr, input int gap,
                        output int nw, output logic [15:0] fa, output logic [15:0] fd);
        int w;
        nw = 0; fa = '0; fd = '0;
        if (dead) return;
        repeat (gap) @(negedge clock);
        w = 0;
        while (char_ready !== 1'b1 && w < 8000) begin
            @(negedge clock);
            w++;
        end
        if (char_ready !== 1'b1) begin
            checks++;
            errors++;
            dead = 1;
            $display("FAIL ready timeout: got char_ready=%b, expected 1 within 8000 cycles", char_ready);
            return;
        end
        model_predict(code, attr);
        char_data  = code;
        char_attr  = attr;
        char_valid = 1'b1;
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        char_data  = 8'($urandom);
        char_attr  = 6'($urandom);
        collect($sformatf("txn%0d", txn), nw, fa, fd);
        $display("txn %0d code=%h attr=%b writes=%0d first=%0d/%h cursor=(%0d,%0d)",
                 txn, code, attr, nw, fa, fd, cursor_row, cursor_col);
        txn++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  code;
        logic [5:0]  attr;
        int          nw;
        logic [15:0] faddr;
        logic [15:0] fdata;
        int          row;
        int          col;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int          nw;
        int          n;
        logic [15:0] fa;
        logic [15:0] fd;
        logic [7:0]  c;

        vecs[0]  = '{8'h41, 6'b111000,    1, 16'd0,   16'h3841, 0, 1};
        vecs[1]  = '{8'h0D, 6'b000000,    0, 16'd0,   16'h0000, 0, 0};
        vecs[2]  = '{8'h0A, 6'b000000,  100, 16'd100, 16'h3820, 1, 0};
        vecs[3]  = '{8'h0A, 6'b000000,  100, 16'd200, 16'h3820, 2, 0};
        vecs[4]  = '{8'h30, 6'b000111,    1, 16'd200, 16'h0730, 2, 1};
        vecs[5]  = '{8'h31, 6'b000111,    1, 16'd201, 16'h0731, 2, 2};
        vecs[6]  = '{8'h01, 6'b101010,    1, 16'd202, 16'h2A01, 2, 3};
        vecs[7]  = '{8'h1F, 6'b000111,    1, 16'd203, 16'h071F, 2, 4};
        vecs[8]  = '{8'h5A, 6'b111111,    1, 16'd204, 16'h3F5A, 2, 5};
        vecs[9]  = '{8'h08, 6'b010101,    1, 16'd204, 16'h1520, 2, 4};
        vecs[10] = '{8'h0D, 6'b000000,    0, 16'd0,   16'h0000, 2, 0};
        vecs[11] = '{8'h08, 6'b010101,    0, 16'd0,   16'h0000, 2, 0};
        vecs[12] = '{8'h0C, 6'b000000, 6000, 16'd0,   16'h3820, 0, 0};

        // ---- reset values ----
        repeat (3) @(negedge clock);
        chk("reset wenable",    int'(wenable),    0);
        chk("reset waddr",      int'(waddr),      0);
        chk("reset wdata",      int'(wdata),      0);
        chk("reset char_ready", int'(char_ready), 0);
        chk("reset busy",       int'(busy),       1);
        chk("reset cursor_row", int'(cursor_row), 0);
        chk("reset cursor_col", int'(cursor_col), 0);

        // ---- reset in the middle of the power-up clear ----
        reset = 1'b0;
        n = 0;
        for (int j = 0; j < 7000 && n < 3000; j++) begin
            @(negedge clock);
            if (wenable === 1'b1) n++;
        end
        chk("midclear writes before reset", n, 3000);
        reset = 1'b1;
        #1;
        chk("midclear reset wenable",    int'(wenable),    0);
        chk("midclear reset waddr",      int'(waddr),      0);
        chk("midclear reset char_ready", int'(char_ready), 0);
        chk("midclear reset busy",       int'(busy),       1);
        @(negedge clock);
        reset = 1'b0;

        // ---- full power-up clear: writes 0..5999, ready one cycle later ----
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        model_full_clear(0);
        collect("powerup clear", nw, fa, fd);
        chk("powerup clear count", nw, 6000);
        chk("powerup clear first addr", int'(fa), 0);
        $display("txn powerup clear writes=%0d", nw);

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].code, vecs[i].attr, i % 3, nw, fa, fd);
            chk($sformatf("vec%0d writes", i), nw, vecs[i].nw);
            if (vecs[i].nw > 0) begin
                chk($sformatf("vec%0d first addr", i), int'(fa), int'(vecs[i].faddr));
                chk($sformatf("vec%0d first data", i), int'(fd), int'(vecs[i].fdata));
            end
            chk($sformatf("vec%0d row", i), int'(cursor_row), vecs[i].row);
            chk($sformatf("vec%0d col", i), int'(cursor_col), vecs[i].col);
        end

        // ---- CR then LF from (10,40) ----
        for (int i = 0; i < 10; i++) send(8'h0A, 6'd0, 0, nw, fa, fd);
        for (int i = 0; i < 40; i++) send(8'h61, 6'b111000, 0, nw, fa, fd);
        chk("pos 10,40 row", int'(cursor_row), 10);
        chk("pos 10,40 col", int'(cursor_col), 40);
        send(8'h0D, 6'd0, 1, nw, fa, fd);
        chk("CR writes", nw, 0);
        chk("CR col", int'(cursor_col), 0);
        send(8'h0A, 6'd0, 0, nw, fa, fd);
        chk("LF writes", nw, 100);
        chk("LF first addr", int'(fa), 1100);
        chk("LF row", int'(cursor_row), 11);

        // ---- glyph at the bottom-right cell ----
        for (int i = 0; i < 48; i++) send(8'h0A, 6'd0, 0, nw, fa, fd);
        for (int i = 0; i < 99; i++) send(8'h2E, 6'b110001, 0, nw, fa, fd);
        chk("pos 59,99 row", int'(cursor_row), 59);
        chk("pos 59,99 col", int'(cursor_col), 99);
        send(8'h78, 6'b100001, 0, nw, fa, fd);
        chk("wrap writes", nw, 101);
        chk("wrap first addr", int'(fa), 5999);
        chk("wrap first data", int'(fd), 16'h2178);
        chk("wrap row", int'(cursor_row), 0);
        chk("wrap col", int'(cursor_col), 0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 300; i++) begin
            n = int'($urandom_range(0, 99));
            if (n < 4)       c = 8'h0A;
            else if (n < 7)  c = 8'h0D;
            else if (n < 12) c = 8'h08;
            else begin
                c = 8'($urandom_range(0, 255));
                if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h2A;
            end
            send(c, 6'($urandom), int'($urandom_range(0, 2)), nw, fa, fd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_console_writer.md
VGA_CONSOLE_WRITER -- requirements
Module: vga_console_writer

Interface
REQ-001 Parameter COLS, default 100: text columns per row.
REQ-002 Parameter ROWS, default 60: text rows per screen.
REQ-003 clock  in  1  single clock, the same clock as the text-buffer write port; all logic is rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 char_valid  in  1  a character byte is offered.
REQ-006 char_data  in  8  character code.
REQ-007 char_attr  in  6  {fg[2:0], bg[2:0]}, sampled together with char_data.
REQ-008 char_ready  out  1  writer accepts char_data this cycle.
REQ-009 wenable  out  1  text-buffer write strobe.
REQ-010 waddr  out  16  cell address, row*COLS+col; upper bits zero.
REQ-011 wdata  out  16  {2'b00, fg[2:0], bg[2:0], code[7:0]}.
REQ-012 cursor_row  out  7  current row.
REQ-013 cursor_col  out  7  current column.
REQ-014 busy  out  1  high in any clear state.

Function
REQ-015 The writer SHALL use the states CLEAR_ALL, IDLE and CLEAR_ROW; char_ready SHALL equal (state==IDLE).
REQ-016 A transfer SHALL occur on a rising edge with char_valid and char_ready both high; char_data and char_attr are held by the source until then.
REQ-017 A printable code SHALL produce one write on the next cycle: wenable=1, waddr=cursor position, wdata={attr,code}. Printable means any code other than 0x08, 0x0A, 0x0C and 0x0D, including the remaining 0x00-0x1F glyphs.
REQ-018 After a printable write, col SHALL increment; at col COLS-1, col becomes 0 and a row advance occurs.
REQ-019 0x0D (CR) SHALL set col=0 with no write.
REQ-020 0x0A (LF) SHALL set col=0 and perform a row advance.
REQ-021 0x08 (BS) with col>0 SHALL decrement col and write {attr,0x20} at the new column; with col==0 it SHALL do nothing.
REQ-022 0x0C (FF) SHALL set the cursor to (0,0) and enter CLEAR_ALL.
REQ-023 A row advance SHALL set row=row+1, wrapping from ROWS-1 to 0, then enter CLEAR_ROW.
REQ-024 CLEAR_ROW SHALL write CLEAR_WORD (16'h3820) to the COLS cells of the new row on COLS consecutive cycles, col ascending, then return to IDLE.
REQ-025 CLEAR_ALL SHALL write CLEAR_WORD to addresses 0 through ROWS*COLS-1 on consecutive cycles, then return to IDLE.
REQ-026 char_ready SHALL be 0 throughout either clear state and SHALL rise on the cycle after its last write.
REQ-027 If a printable write at (ROWS-1, COLS-1) is accepted, the writer SHALL write address 5999 and then clear row 0 at addresses 0-99.
REQ-028 wenable, waddr and wdata SHALL be registered outputs; wenable is 0 in every cycle with no write.
REQ-029 cursor_row and cursor_col SHALL reflect the post-update cursor on the cycle after acceptance.

Reset
REQ-030 While reset is high, outputs SHALL be: wenable=0, waddr=0, wdata=0, char_ready=0, cursor=(0,0), busy=1, state=CLEAR_ALL, clear counter=0.
REQ-031 On the first edge after reset release, the full-screen clear SHALL begin; the first write is to waddr 0.
REQ-032 A reset asserted during any state, including mid-clear, SHALL abort immediately and restart the full clear.

Structure
REQ-033 Package vga_text_pkg SHALL hold COLS/ROWS defaults, CELLS=6000, CLEAR_WORD, the control-code constants (BS, LF, FF, CR) and the state enum.
REQ-034 The writer SHALL be a single module with no sub-modules; the address multiply is a registered row*COLS+col.

Verification
REQ-035 Reset, then release -> exactly 6000 consecutive writes, waddr 0..5999, wdata 16'h3820; char_ready rises at cycle 6001.
REQ-036 Send 'A' (0x41) with attr 6'b111000 at (0,0) -> one write: waddr 0, wdata 16'h3841; cursor becomes (0,1).
REQ-037 Cursor at (2,5), send 0x08 -> write waddr 204, wdata {attr,0x20}; cursor (2,4). Repeated at col 0 -> no write.
REQ-038 Cursor at (59,99), send 'x' -> write waddr 5999, then 100 writes to waddr 0..99; char_ready low throughout; cursor ends at (0,0).
REQ-039 Cursor at (10,40), send 0x0D then 0x0A -> no write on CR; LF clears waddr 1100..1199; cursor (11,0).
REQ-040 Assert reset at clear count 3000, release -> clear restarts at waddr 0 and completes all 6000 writes.
